// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks (transmitter, receiver):
//   - transmitter FSM state encoding
//   - common keyboard command / response bytes
//   - default tick counts for a 7 MHz clock enable
//   - frame builder for the host-to-device shift register
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_DATA    = 3'd3,
        ST_ACK     = 3'd4,
        ST_END     = 3'd5
    } ps2_state_t;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // 120 us inhibit and 15 ms device timeout at a 7 MHz enable.
    localparam int INHIBIT_DEF = 840;
    localparam int TIMEOUT_DEF = 105000;
    localparam int TW_DEF      = 17;

    // Bits shifted out LSB first after the start bit: data, odd parity, stop.
    function automatic logic [9:0] ps2_frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync
// Brings the asynchronous PS/2 clock and data pins into the system clock
// domain and flags falling edges of the PS/2 clock.
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous active-low reset
//   ce      in   clock enable; edge history only advances on enabled ticks
//   ckI     in   raw PS/2 clock pin level
//   dqI     in   raw PS/2 data pin level
//   ckSync  out  synchronised PS/2 clock
//   dqSync  out  synchronised PS/2 data
//   fall    out  PS/2 clock falling edge, valid on ce ticks only
module ps2_sync
    import ps2_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic ckI,
    input  logic dqI,
    output logic ckSync,
    output logic dqSync,
    output logic fall
);

    logic ckMeta;
    logic dqMeta;
    logic ckPrev;

    // Synchronisers run every clock; only the edge history is ce-gated, so a
    // fall that happens between enables is still seen on the next ce tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ckMeta <= 1'b1;
            ckSync <= 1'b1;
            dqMeta <= 1'b1;
            dqSync <= 1'b1;
            ckPrev <= 1'b1;
        end else begin
            ckMeta <= ckI;
            ckSync <= ckMeta;
            dqMeta <= dqI;
            dqSync <= dqMeta;
            if (ce) begin
                ckPrev <= ckSync;
            end
        end
    end

    assign fall = ce & ckPrev & ~ckSync;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx
// PS/2 host-to-device transmitter. Sends one byte to the keyboard using the
// host request sequence: clock inhibit, request-to-send, 8 data bits, odd
// parity, stop, then reads the device ACK. Pins are open drain; the top level
// turns ckOe/dqOe into pull-lows.
//
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-low reset
//   ce     in   clock enable; all state advances only on ce ticks
//   tx     in   start request, accepted when idle
//   d      in   byte to send, captured on accept
//   ckI    in   PS/2 clock pin level (asynchronous)
//   dqI    in   PS/2 data pin level (asynchronous)
//   ckOe   out  1 = pull PS/2 clock low
//   dqOe   out  1 = pull PS/2 data low
//   busy   out  transfer in progress (accept tick through done tick)
//   done   out  one ce tick pulse at end of transfer
//   err    out  last transfer timed out or was NACKed; held until next accept
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | lines released, waiting for tx
// ST_INHIBIT | clock held low for INHIBIT ticks
// ST_REQ     | data low (start bit), clock about to be released
// ST_DATA    | device clocking; new bit presented on each clock fall
// ST_ACK     | stop bit out; device ACK sampled on the next fall
// ST_END     | waiting for both lines to return high
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = INHIBIT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       tx,
    input  logic [7:0] d,
    input  logic       ckI,
    input  logic       dqI,
    output logic       ckOe,
    output logic       dqOe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] CNT_ONE  = TW'(1);

    ps2_state_t    state;
    logic [9:0]    sr;
    logic [3:0]    idx;
    logic [TW-1:0] cnt;

    logic ckSync;
    logic dqSync;
    logic fall;

    ps2_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .ckI    (ckI),
        .dqI    (dqI),
        .ckSync (ckSync),
        .dqSync (dqSync),
        .fall   (fall)
    );

    // cnt is a down-counter: loaded at the start of a timed phase and
    // terminating at zero. The DATA/ACK timeout spans the whole frame and is
    // only reloaded when entering DATA, never per bit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
            sr    <= '0;
            idx   <= '0;
            cnt   <= '0;
            ckOe  <= 1'b0;
            dqOe  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx) begin
                        sr    <= ps2_frame(d);
                        cnt   <= INH_LOAD;
                        idx   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        ckOe  <= 1'b1;
                        dqOe  <= 1'b0;
                        state <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (cnt == '0) begin
                        dqOe  <= 1'b1;
                        state <= ST_REQ;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                ST_REQ: begin
                    ckOe  <= 1'b0;
                    idx   <= '0;
                    cnt   <= TO_LOAD;
                    state <= ST_DATA;
                end

                ST_DATA: begin
                    if (cnt == '0) begin
                        ckOe  <= 1'b0;
                        dqOe  <= 1'b0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (fall) begin
                            // Open drain: a 0 bit means pull the line low.
                            dqOe <= ~sr[0];
                            sr   <= {1'b0, sr[9:1]};
                            idx  <= idx + 4'd1;
                            if (idx == 4'd9) begin
                                state <= ST_ACK;
                            end
                        end
                    end
                end

                ST_ACK: begin
                    if (cnt == '0) begin
                        ckOe  <= 1'b0;
                        dqOe  <= 1'b0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (fall) begin
                            err   <= dqSync;
                            state <= ST_END;
                        end
                    end
                end

                ST_END: begin
                    if (ckSync && dqSync) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    ckOe  <= 1'b0;
                    dqOe  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx
// Directed bench for ps2_tx: a table of bytes driven through a simple PS/2
// device model, plus hand-written sequences for timeout, mid-frame reset and
// tx while busy. The enable runs three ticks out of every four clocks.
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int TO_TB = 2000;
    localparam int HALF  = 40;

    typedef struct {
        logic [7:0] d;
        bit         nack;
        bit         par;
        bit         err;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ce    = 1'b0;
    logic       tx    = 1'b0;
    logic [7:0] d     = 8'h00;
    logic       ckOe, dqOe, busy, done, err;
    logic       devCk = 1'b1;
    logic       devDq = 1'b1;
    logic       ckI, dqI;

    int checks   = 0;
    int failures = 0;
    int doneTot  = 0;
    int inhTot   = 0;
    int relTot   = 0;
    logic doneQ  = 1'b0;
    logic [1:0] ph = 2'd0;

    assign ckI = devCk & ~ckOe;
    assign dqI = devDq & ~dqOe;

    ps2_tx #(.INHIBIT(INHIBIT_DEF), .TIMEOUT(TO_TB), .TW(TW_DEF)) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .tx    (tx),
        .d     (d),
        .ckI   (ckI),
        .dqI   (dqI),
        .ckOe  (ckOe),
        .dqOe  (dqOe),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clock = ~clock;

    // ce changes just after each rising edge, so at the falling edge it shows
    // whether the coming rising edge is an enabled tick.
    always @(posedge clock) begin
        #1;
        ph = ph + 2'd1;
        ce = (ph != 2'd3);
    end

    always @(negedge clock) begin
        if (done && !doneQ) doneTot++;
        doneQ = done;
        if (ce && ckOe && !dqOe) inhTot++;
        if (ce && reset && busy && !ckOe) relTot++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clock);
        d  = b;
        tx = 1'b1;
        while (!ce) @(negedge clock);
        @(negedge clock);
        tx = 1'b0;
    endtask

    task automatic wait_rts();
        int n = 0;
        while (!(dqOe && !ckOe) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("rts_seen", {30'd0, dqOe, ckOe}, 32'd2);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clock);
            n++;
        end
        chk("busy_clear", busy, 0);
    endtask

    // Device model: bit k of the frame is read in the low half after fall k.
    // bits[0] is the start bit seen before the first fall.
    task automatic dev_clock(input int nfalls, input bit nack, output logic [10:0] bits);
        bits = '0;
        ticks(HALF);
        bits[0] = dqI;
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && !nack) begin
                devDq = 1'b0;
                ticks(HALF / 2);
            end
            devCk = 1'b0;
            ticks(HALF);
            if (k <= 10) bits[k] = dqI;
            devCk = 1'b1;
            ticks(HALF);
        end
        devDq = 1'b1;
    endtask

    initial begin
        vec_t       vt [7];
        logic [10:0] bits;
        int         db, ib, rb;

        vt[0] = '{8'hED, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vt[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vt[3] = '{8'hED, 1'b1, 1'b1, 1'b1};
        vt[4] = '{8'h01, 1'b0, 1'b0, 1'b0};
        vt[5] = '{8'hF4, 1'b0, 1'b0, 1'b0};
        vt[6] = '{8'hFA, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        ticks(10);
        chk("rst_ckoe", ckOe, 0);
        chk("rst_dqoe", dqOe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err,  0);
        reset = 1'b1;
        ticks(8);

        for (int i = 0; i < 7; i++) begin
            db = doneTot;
            ib = inhTot;
            start_tx(vt[i].d);
            chk("accept_busy", busy, 1);
            chk("accept_ckoe", ckOe, 1);
            chk("accept_err_clear", err, 0);
            wait_rts();
            chk("inhibit_ticks", inhTot - ib, INHIBIT_DEF);
            dev_clock(11, vt[i].nack, bits);
            chk("frame_bits", bits, {1'b1, vt[i].par, vt[i].d, 1'b0});
            wait_idle(200);
            ticks(8);
            chk("xfer_err", err, vt[i].err);
            chk("xfer_done_pulses", doneTot - db, 1);
            chk("xfer_lines_free", {ckOe, dqOe}, 0);
        end

        // tx while busy with a different byte is ignored
        db = doneTot;
        start_tx(CMD_SET_LED);
        ticks(100);
        d  = 8'h55;
        tx = 1'b1;
        ticks(8);
        tx = 1'b0;
        chk("busy_still", busy, 1);
        wait_rts();
        dev_clock(11, 1'b0, bits);
        chk("busy_tx_bits", bits, {1'b1, 1'b1, 8'hED, 1'b0});
        wait_idle(200);
        ticks(20);
        chk("busy_tx_done", doneTot - db, 1);
        chk("busy_tx_no_requeue", busy, 0);

        // device never clocks: timeout TIMEOUT ticks after entering DATA
        db = doneTot;
        start_tx(CMD_RESET);
        rb = relTot;
        wait_rts();
        wait_idle(TO_TB * 2);
        ticks(4);
        chk("timeout_ticks", relTot - rb, TO_TB);
        chk("timeout_err", err, 1);
        chk("timeout_lines", {ckOe, dqOe}, 0);
        chk("timeout_done", doneTot - db, 1);

        // reset during bit 4, then a clean transfer
        start_tx(CMD_SET_LED);
        chk("rst_mid_err_clear", err, 0);
        wait_rts();
        dev_clock(4, 1'b0, bits);
        chk("rst_mid_busy_before", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_ckoe", ckOe, 0);
        chk("rst_mid_dqoe", dqOe, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_err",  err,  0);
        chk("rst_mid_done", done, 0);
        ticks(3);
        reset = 1'b1;
        ticks(8);
        db = doneTot;
        start_tx(CMD_ENABLE);
        wait_rts();
        dev_clock(11, 1'b0, bits);
        chk("post_rst_bits", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        wait_idle(200);
        ticks(8);
        chk("post_rst_err", err, 0);
        chk("post_rst_done", doneTot - db, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter. It is the send direction for the existing PS/2 receiver on the shared keybCk/keybDQ pins.
- Sends one command or data byte to the keyboard, for example ED/LED-state or FF/reset. It follows the PS/2 host-request sequence: inhibit, request-to-send, 8 data bits, parity, stop, device ACK.
- Sits beside the receiver in the top level. The top resolves open-drain pins as "ps2Ck = ckOe ? 1'b0 : 1'bZ" (same form for DQ).
- The receiver sees the same pins and ignores traffic while busy=1.

Parameters:
- INHIBIT, 840, ce ticks clock is held low before the start bit (120 us at 7 MHz ce).
- TIMEOUT, 105000, ce ticks allowed from clock release to ACK (15 ms at 7 MHz ce).
- TW, 17, width of the shared tick counter; must hold max(INHIBIT, TIMEOUT).

Ports:
- clock  in   1  system clock (56 MHz).
- reset  in   1  synchronous, active-low reset.
- ce     in   1  clock enable (ne7M0). All state advances only when ce=1.
- tx     in   1  start request, sampled when ce=1 and busy=0.
- d      in   8  byte to send, captured when tx is accepted.
- ckI    in   1  PS/2 clock pin level (asynchronous).
- dqI    in   1  PS/2 data pin level (asynchronous).
- ckOe   out  1  1 = pull PS/2 clock low.
- dqOe   out  1  1 = pull PS/2 data low.
- busy   out  1  transfer in progress.
- done   out  1  one-ce-tick pulse at end of transfer.
- err    out  1  status of the last transfer: 1 = timeout or NACK; held until next accept.

Behaviour:
- Reset (reset=0 at posedge clock): state=IDLE, ckOe=0, dqOe=0, busy=0, done=0, err=0, counters=0. Reset mid-transfer releases both lines on the next clock edge.
- Input conditioning:
  - ckI and dqI each pass through a 2-flop synchroniser clocked on every clock edge.
  - fall = ckPrev & ~ckSync, evaluated on ce ticks only.
  - ckPrev updates on ce ticks.
- Parity: shift register sr[9:0] = {1'b1 stop, ~^d odd parity, d[7:0]}, loaded on accept.
- IDLE:
  - tx=1 → load sr, counter=0, err=0, busy=1, ckOe=1, go to INHIBIT.
  - Latency from accept to ckOe=1 is one ce tick.
- INHIBIT:
  - Count ce ticks. At count==INHIBIT-1: dqOe=1 (start bit), go to REQ.
- REQ:
  - One ce tick later: ckOe=0, bit index=0, counter=0, go to DATA.
- DATA:
  - On each fall: dqOe = ~sr[0], sr shifts right, index increments.
  - After the 10th fall (stop bit presented, dqOe=0) go to ACK.
- ACK:
  - On the next fall, sample dqSync. 0 = ACK (err=0), 1 = NACK (err=1).
  - Then go to END.
- END:
  - Wait for ckSync=1 and dqSync=1 (line idle).
  - Then done=1 for one ce tick, busy=0, go to IDLE.
- Timeout:
  - Counter runs in DATA and ACK and resets only on entry to DATA. It is not restarted per bit.
  - At counter==TIMEOUT-1: ckOe=0, dqOe=0, err=1, done pulse, busy=0, go to IDLE.
  - Timeout does not wait for the line to be idle.
- tx while busy=1 is ignored; no queueing.
- tx and a timeout on the same tick: timeout wins; tx is not accepted until the next tick in IDLE.
- Counter saturates at TIMEOUT-1 and never wraps.
- A fall with ce=0 is not lost: ckPrev holds and the edge is detected on the next ce tick. The PS/2 clock is ≤16.7 kHz, far below the ce rate.
- busy is high from the accept tick through the done tick, inclusive of IDLE re-entry timing above.

Decomposition:
- Shared package (ps2_pkg) holds:
  - state encodings: IDLE, INHIBIT, REQ, DATA, ACK, END;
  - PS/2 command constants: 8'hED set LEDs, 8'hFF reset, 8'hF4 enable, 8'hFA ack byte;
  - default INHIBIT/TIMEOUT values for the 7 MHz ce.
- One natural sub-module: ps2_sync.
  - 2-flop synchroniser plus falling-edge detect.
  - Reusable by the receiver.
- The remainder stays flat.

Test Plan:
1. d=8'hED, tx pulse; device model clocks 11 falls at 10 kHz and drives dqI=0 on the 11th:
   - ckOe high for exactly 840 ce ticks, then dqOe=1;
   - bits seen on falls 1..10 are 1,0,1,1,0,1,1,1, parity=1, stop=1;
   - err=0, done pulses once, busy=0 after.
2. d=8'h00: parity bit = 1. d=8'hFF: parity bit = 1. d=8'h01: parity bit = 0. Stop always 1 with dqOe=0.
3. Device gives 11 falls but holds dqI=1 on the ACK fall → err=1, done pulses once.
4. Device never clocks after release → exactly TIMEOUT ticks after entering DATA: err=1, done pulses, ckOe=dqOe=0, busy=0.
5. reset=0 asserted during bit 4 → the next clock edge gives ckOe=dqOe=busy=err=done=0; a new tx=8'hF4 then completes normally.
6. tx pulsed again while busy with d=8'h55 → ignored; the byte on the wire remains the first one (8'hED); only one done pulse.
